// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit ripple-carry slice per clock,
// LSB nibble first, with valid/ready handshakes on both sides.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx;
  logic             accept;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  ripple_carry_adder u_rca (
    .a    (a_reg[4*idx +: 4]),
    .b    (b_reg[4*idx +: 4]),
    .cin  (carry_reg),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)        state_nxt = RUN;
      RUN:  if (idx == LAST)   state_nxt = DONE;
      DONE: if (out_ready)     state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are always loaded at accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= in_a;
      b_reg <= in_sub ? ~in_b : in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_reg <= 1'b0;
      idx       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      carry_reg <= in_sub;
      idx       <= '0;
    end else if (state == RUN) begin
      out_sum[4*idx +: 4] <= nib_sum;
      carry_reg           <= nib_cout;
      idx                 <= idx + 1'b1;
      if (idx == LAST) begin
        // Signed overflow: operands agree in sign but the result does not.
        out_cout <= nib_cout;
        out_ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (nib_sum[3] != a_reg[WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized self-checking bench for nibble_serial_add_ctrl at WIDTH=16 and WIDTH=4,
// compared against an integer-arithmetic reference model.

module tb_nibble_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sub, out_ready, sel4;
  logic [15:0] in_a, in_b;

  logic        ir16, ov16, co16, of16, b16;
  logic [15:0] s16;
  logic        ir4, ov4, co4, of4, b4;
  logic [3:0]  s4;

  logic        obs_ready, obs_valid, obs_cout, obs_ovf, obs_busy;
  logic [15:0] obs_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && !sel4), .in_ready(ir16),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(ov16), .out_ready(out_ready),
    .out_sum(s16), .out_cout(co16), .out_ovf(of16), .busy(b16)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel4), .in_ready(ir4),
    .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_sub(in_sub),
    .out_valid(ov4), .out_ready(out_ready),
    .out_sum(s4), .out_cout(co4), .out_ovf(of4), .busy(b4)
  );

  assign obs_ready = sel4 ? ir4 : ir16;
  assign obs_valid = sel4 ? ov4 : ov16;
  assign obs_sum   = sel4 ? {12'h000, s4} : s16;
  assign obs_cout  = sel4 ? co4 : co16;
  assign obs_ovf   = sel4 ? of4 : of16;
  assign obs_busy  = sel4 ? b4  : b16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {ovf, cout, sum} from plain signed/unsigned integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input int w);
    longint m, half, aa, bb, full, sa, sb, r;
    logic   cout, ovf;
    m    = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    aa   = longint'(a) & m;
    bb   = longint'(b) & m;
    full = sub ? (aa - bb + (m + 1)) : (aa + bb);
    cout = ((full >>> w) & 1) != 0;
    sa   = (aa >= half) ? aa - (m + 1) : aa;
    sb   = (bb >= half) ? bb - (m + 1) : bb;
    r    = sub ? (sa - sb) : (sa + sb);
    ovf  = (r >= half) || (r < -half);
    return {ovf, cout, 16'(full & m)};
  endfunction

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input int hold);
    int          w, n, edges;
    logic [17:0] exp;
    logic [15:0] held;
    w   = sel4 ? 4 : 16;
    n   = w / 4;
    exp = model(a, b, sub, w);
    @(negedge clk);
    check("idle_ready", obs_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
    check("run_ready", obs_ready, 0);
    edges = 0;
    while (!obs_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("latency", edges, n);
    check("sum", obs_sum, exp[15:0]);
    check("cout", obs_cout, exp[16]);
    check("ovf", obs_ovf, exp[17]);
    check("done_busy", obs_busy, 1);
    check("done_ready", obs_ready, 0);
    held = obs_sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", obs_valid, 1);
      check("bp_sum", obs_sum, held);
      check("bp_ready", obs_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("done_ready_with_oready", obs_ready, 0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", obs_valid, 0);
    check("post_busy", obs_busy, 0);
    check("post_ready", obs_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b0; sel4 = 1'b0;
    in_a = '0; in_b = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", ir16, 0);
    check("rst_valid", ov16, 0);
    check("rst_sum", s16, 0);
    check("rst_cout", co16, 0);
    check("rst_ovf", of16, 0);
    check("rst_busy", b16, 0);
    rst = 1'b0;
    #1 check("rel_ready", ir16, 1);

    run_txn(16'h1234, 16'h4321, 1'b0, 0);
    run_txn(16'hFFFF, 16'h0001, 1'b0, 0);
    run_txn(16'h0FFF, 16'h0001, 1'b0, 0);
    run_txn(16'h7FFF, 16'h0001, 1'b0, 0);
    run_txn(16'h0003, 16'h0005, 1'b1, 0);
    run_txn(16'h0005, 16'h0005, 1'b1, 0);
    run_txn(16'h1234, 16'h4321, 1'b0, 10);
    run_txn(16'hABCD, 16'h1357, 1'b1, 0);
    run_txn(16'h8000, 16'h0001, 1'b1, 0);

    // Abort 0x1234+0x4321 after two nibbles, then 0xFFFF+0x0001 likewise.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = (k == 0) ? 16'h1234 : 16'hFFFF;
      in_b = (k == 0) ? 16'h4321 : 16'h0001;
      in_sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_valid", ov16, 0);
      check("abort_sum", s16, 0);
      check("abort_cout", co16, 0);
      check("abort_ovf", of16, 0);
      check("abort_busy", b16, 0);
      check("abort_ready", ir16, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("abort_rel_ready", ir16, 1);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check("abort_no_valid", ov16, 0);
      end
    end
    run_txn(16'h0001, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 30; i++)
      run_txn(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    sel4 = 1'b1;
    run_txn(16'h000F, 16'h0001, 1'b0, 0);
    run_txn(16'h0007, 16'h0001, 1'b0, 0);
    run_txn(16'h0008, 16'h0001, 1'b1, 2);
    for (int i = 0; i < 12; i++)
      run_txn(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
